// File: rtl/fib_stream_gen.sv
// Seeded generalised-Fibonacci term source over valid/ready; FIB_SAT_EN selects saturating sums instead of wrap.
// Latency: first term one cycle after an accepted start; one term per cycle while out_ready=1, term held stable while out_ready=0.
module fib_stream_gen #(
  parameter int bW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [bW-1:0] seed_a,
  input  logic [bW-1:0] seed_b,
  input  logic [CW-1:0] num_terms,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [bW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [bW-1:0] cur_q;
  logic [bW-1:0] nxt_q;
  logic          nxt_c_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic [bW:0]   sum;
  logic [bW-1:0] sum_term;
  logic          accept;
  logic          fire;
  logic          last;

  // cur_q is the presented term, nxt_q the one after it; nxt_c_q remembers its carry
  assign sum = {1'b0, cur_q} + {1'b0, nxt_q};

`ifdef FIB_SAT_EN
  assign sum_term = sum[bW] ? {bW{1'b1}} : sum[bW-1:0];
`else
  assign sum_term = sum[bW-1:0];
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fire    = 1'b0;
    last    = (cnt_q == CW'(1));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_terms == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          fire = 1'b1;
          if (last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      nxt_c_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_q   <= seed_a;
        nxt_q   <= seed_b;
        nxt_c_q <= 1'b0;
        cnt_q   <= num_terms;
        ovf_q   <= 1'b0;
      end else if (fire) begin
        cnt_q <= cnt_q - CW'(1);
        // On the final handshake the last term stays on out_data
        if (!last) begin
          cur_q   <= nxt_q;
          nxt_q   <= sum_term;
          nxt_c_q <= sum[bW];
          ovf_q   <= ovf_q | nxt_c_q;
        end
      end
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_data  = cur_q;
  assign ovf       = ovf_q;

endmodule
